// File: rtl/mem_pkg.sv
// Shared memory-bus widths and arbiter state type.
// Used by the arbiter, the SRAM controller and the core.
package mem_pkg;

   localparam int ADR_W = 18;
   localparam int DAT_W = 16;
   localparam int SEL_W = 2;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick with last-grant pointer.
// Ports: clk, rst (async low), req_i[1:0], take_i, gnt_o.
module arb_rr2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req_i,
   input  logic       take_i,
   output logic       gnt_o
);

   logic last_q;

   // On a tie the master not granted last wins.
   always_comb begin
      gnt_o = 1'b0;
      unique case (req_i)
         2'b11:   gnt_o = ~last_q;
         2'b10:   gnt_o = 1'b1;
         default: gnt_o = 1'b0;
      endcase
   end

   // Pointer starts at 1 so m0 wins the first tie.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         last_q <= 1'b1;
      end else if (take_i && (|req_i)) begin
         last_q <= gnt_o;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master memory arbiter with ack timeout.
// Ports: clk, rst, m0_*/m1_* masters, s_* slave, busy.
module mem_arbiter
   import mem_pkg::*;
#(
   parameter logic [7:0] TIMEOUT = 8'd255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [ADR_W-1:0] m0_adr,
   input  logic             m0_req,
   input  logic             m0_write,
   input  logic [SEL_W-1:0] m0_sel,
   input  logic [DAT_W-1:0] m0_wdata,
   output logic             m0_ack,
   output logic             m0_err,
   output logic [DAT_W-1:0] m0_rdata,
   input  logic [ADR_W-1:0] m1_adr,
   input  logic             m1_req,
   input  logic             m1_write,
   input  logic [SEL_W-1:0] m1_sel,
   input  logic [DAT_W-1:0] m1_wdata,
   output logic             m1_ack,
   output logic             m1_err,
   output logic [DAT_W-1:0] m1_rdata,
   output logic [ADR_W-1:0] s_adr,
   output logic             s_req,
   output logic             s_write,
   output logic [SEL_W-1:0] s_sel,
   output logic [DAT_W-1:0] s_wdata,
   input  logic             s_ack,
   input  logic [DAT_W-1:0] s_rdata,
   output logic             busy
);

   state_t           state_q;
   logic             gnt_q;
   logic [7:0]       cnt_q;
   logic [7:0]       cnt_d;
   logic [ADR_W-1:0] adr_q;
   logic             req_q;
   logic             we_q;
   logic [SEL_W-1:0] sel_q;
   logic [DAT_W-1:0] wd_q;
   logic             pick;
   logic             busy_w;
   logic             tmo;
   logic             done;

   arb_rr2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .req_i  ({m1_req, m0_req}),
      .take_i (state_q == IDLE),
      .gnt_o  (pick)
   );

   assign busy_w = (state_q == BUSY);

   // A real ack in the timeout cycle wins over the abort.
   assign tmo  = busy_w & ~s_ack & (cnt_q == TIMEOUT);
   assign done = busy_w & (s_ack | tmo);

   always_comb begin
      cnt_d = cnt_q;
      if (state_q == IDLE) begin
         cnt_d = '0;
      end else if (!done) begin
         cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         gnt_q   <= 1'b0;
         cnt_q   <= '0;
         adr_q   <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         sel_q   <= '0;
         wd_q    <= '0;
      end else begin
         cnt_q <= cnt_d;
         unique case (state_q)
            IDLE: begin
               if (m0_req || m1_req) begin
                  state_q <= BUSY;
                  gnt_q   <= pick;
                  req_q   <= 1'b1;
                  adr_q   <= pick ? m1_adr   : m0_adr;
                  we_q    <= pick ? m1_write : m0_write;
                  sel_q   <= pick ? m1_sel   : m0_sel;
                  wd_q    <= pick ? m1_wdata : m0_wdata;
               end
            end
            BUSY: begin
               if (done) begin
                  state_q <= IDLE;
                  req_q   <= 1'b0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign s_adr   = adr_q;
   assign s_req   = req_q;
   assign s_write = we_q;
   assign s_sel   = sel_q;
   assign s_wdata = wd_q;
   assign busy    = busy_w;

   assign m0_ack   = done & ~gnt_q;
   assign m1_ack   = done &  gnt_q;
   assign m0_err   = tmo  & ~gnt_q;
   assign m1_err   = tmo  &  gnt_q;
   assign m0_rdata = tmo ? '0 : s_rdata;
   assign m1_rdata = tmo ? '0 : s_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter.
// Directed table, corner sequences, random vs model.
module tb_mem_arbiter;

   localparam logic [7:0] TO = 8'd12;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [17:0] m0_adr = '0, m1_adr = '0;
   logic        m0_req = 0, m0_write = 0;
   logic        m1_req = 0, m1_write = 0;
   logic [1:0]  m0_sel = '0, m1_sel = '0;
   logic [15:0] m0_wdata = '0, m1_wdata = '0;
   logic        m0_ack, m0_err, m1_ack, m1_err;
   logic [15:0] m0_rdata, m1_rdata;
   logic [17:0] s_adr;
   logic        s_req, s_write;
   logic [1:0]  s_sel;
   logic [15:0] s_wdata;
   logic        s_ack = 1'b0;
   logic [15:0] s_rdata = '0;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .m0_adr(m0_adr), .m0_req(m0_req),
      .m0_write(m0_write), .m0_sel(m0_sel),
      .m0_wdata(m0_wdata), .m0_ack(m0_ack),
      .m0_err(m0_err), .m0_rdata(m0_rdata),
      .m1_adr(m1_adr), .m1_req(m1_req),
      .m1_write(m1_write), .m1_sel(m1_sel),
      .m1_wdata(m1_wdata), .m1_ack(m1_ack),
      .m1_err(m1_err), .m1_rdata(m1_rdata),
      .s_adr(s_adr), .s_req(s_req),
      .s_write(s_write), .s_sel(s_sel),
      .s_wdata(s_wdata), .s_ack(s_ack),
      .s_rdata(s_rdata), .busy(busy)
   );

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h",
                  nm, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      m0_req = 0; m1_req = 0;
      s_ack = 0; s_rdata = '0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   typedef struct {
      logic        m0r, m1r, sack;
      logic [15:0] srd;
      logic        esreq, ebusy, ea0, ea1;
      int          fld;
   } vec_t;

   vec_t tv[13];

   // Random-phase agent and model state
   bit          act[2], drp[2];
   logic [17:0] ra[2];
   logic        rw[2];
   logic [1:0]  rs[2];
   logic [15:0] rd[2];
   bit          mb;
   int          gm, age, last, pct;
   logic [17:0] la;
   logic        lw;
   logic [1:0]  ls;
   logic [15:0] ld;

   // Timeout / late-ack sequence; ackit selects
   // whether the slave acks in the timeout cycle.
   task automatic tmo_seq(input bit ackit);
      do_reset();
      @(negedge clk);
      m0_req = 1;
      m0_adr = 18'h00123; m0_write = 0;
      @(negedge clk);
      for (int k = 0; k < TO; k++) begin
         #1;
         chk("tmo_wait_ack", m0_ack, 0);
         chk("tmo_wait_busy", busy, 1);
         @(negedge clk);
      end
      s_ack = ackit;
      s_rdata = ackit ? 16'h5A5A : 16'hFFFF;
      #1;
      chk("tmo_ack", m0_ack, 1);
      chk("tmo_err", m0_err, ackit ? 0 : 1);
      chk("tmo_rdata", m0_rdata,
          ackit ? 16'h5A5A : 16'h0000);
      chk("tmo_m1_ack", m1_ack, 0);
      chk("tmo_sreq_hold", s_req, 1);
      @(negedge clk);
      m0_req = 0; s_ack = 0;
      #1;
      chk("tmo_sreq_drop", s_req, 0);
      chk("tmo_idle", busy, 0);
      chk("tmo_err_end", m0_err, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit hit");
      $fatal(1);
   end

   initial begin
      // Reset state
      @(negedge clk);
      #1;
      chk("rst_sreq", s_req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_adr", s_adr, 0);
      chk("rst_write", s_write, 0);
      chk("rst_sel", s_sel, 0);
      chk("rst_wdata", s_wdata, 0);
      s_ack = 1;
      #1;
      chk("rst_acks", {m0_ack, m1_ack}, 0);
      chk("rst_errs", {m0_err, m1_err}, 0);
      s_ack = 0;
      rst = 1'b1;

      // Tie sequence, m0 read then m1 write
      m0_adr = 18'h00010; m0_write = 0;
      m0_sel = 2'b11; m0_wdata = 16'h1234;
      m1_adr = 18'h3FFFF; m1_write = 1;
      m1_sel = 2'b01; m1_wdata = 16'h00A5;
      tv[0]  = '{1,1,0,16'h0,   0,0,0,0,0};
      tv[1]  = '{1,1,0,16'h0,   1,1,0,0,1};
      tv[2]  = '{1,1,0,16'h0,   1,1,0,0,1};
      tv[3]  = '{1,1,1,16'hBEEF,1,1,1,0,1};
      tv[4]  = '{1,1,0,16'h0,   0,0,0,0,0};
      tv[5]  = '{1,1,0,16'h0,   1,1,0,0,2};
      tv[6]  = '{1,1,0,16'h0,   1,1,0,0,2};
      tv[7]  = '{1,1,1,16'h2222,1,1,0,1,2};
      tv[8]  = '{1,1,0,16'h0,   0,0,0,0,0};
      tv[9]  = '{1,1,0,16'h0,   1,1,0,0,1};
      tv[10] = '{1,1,1,16'h3333,1,1,1,0,1};
      tv[11] = '{0,0,0,16'h0,   0,0,0,0,0};
      tv[12] = '{0,0,1,16'h4444,0,0,0,0,0};
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         m0_req = tv[i].m0r;
         m1_req = tv[i].m1r;
         s_ack = tv[i].sack;
         s_rdata = tv[i].srd;
         #1;
         chk("tv_sreq", s_req, tv[i].esreq);
         chk("tv_busy", busy, tv[i].ebusy);
         chk("tv_m0_ack", m0_ack, tv[i].ea0);
         chk("tv_m1_ack", m1_ack, tv[i].ea1);
         chk("tv_errs", {m0_err, m1_err}, 0);
         if (tv[i].ea0)
            chk("tv_m0_rdata", m0_rdata, tv[i].srd);
         if (tv[i].ea1)
            chk("tv_m1_rdata", m1_rdata, tv[i].srd);
         if (tv[i].fld == 1) begin
            chk("tv_adr0", s_adr, 18'h00010);
            chk("tv_we0", s_write, 0);
            chk("tv_sel0", s_sel, 2'b11);
            chk("tv_wd0", s_wdata, 16'h1234);
         end
         if (tv[i].fld == 2) begin
            chk("tv_adr1", s_adr, 18'h3FFFF);
            chk("tv_we1", s_write, 1);
            chk("tv_sel1", s_sel, 2'b01);
            chk("tv_wd1", s_wdata, 16'h00A5);
         end
      end

      // Timeout abort, then ack in timeout cycle
      tmo_seq(1'b0);
      tmo_seq(1'b1);

      // Reset in second BUSY cycle, late ack
      do_reset();
      @(negedge clk);
      m0_req = 1;
      @(negedge clk);
      #1;
      chk("mr_busy", busy, 1);
      @(posedge clk);
      #2;
      s_ack = 1;
      rst = 0;
      #1;
      chk("mr_sreq", s_req, 0);
      chk("mr_busy0", busy, 0);
      chk("mr_ack", m0_ack, 0);
      @(negedge clk);
      rst = 1; m0_req = 0; s_ack = 1;
      #1;
      chk("mr_late_ack", m0_ack, 0);
      chk("mr_late_busy", busy, 0);
      @(negedge clk);
      s_ack = 0;
      #1;
      chk("mr_still_idle", s_req, 0);

      // Random traffic against model
      do_reset();
      mb = 0; gm = 0; age = 0; last = 1;
      la = '0; lw = 0; ls = '0; ld = '0;
      pct = 30;
      for (int n = 0; n < 2; n++) begin
         act[n] = 0; drp[n] = 0;
      end
      for (int c = 0; c < 4000; c++) begin
         bit tmo_e, dn;
         bit ea[2];
         int p;
         @(negedge clk);
         if (c % 250 == 0) begin
            case ($urandom_range(0, 2))
               0: pct = 2;
               1: pct = 30;
               default: pct = 70;
            endcase
         end
         for (int n = 0; n < 2; n++) begin
            if (!act[n] && !drp[n] &&
                $urandom_range(0, 3) == 0) begin
               act[n] = 1;
               ra[n] = 18'($urandom);
               rw[n] = 1'($urandom);
               rs[n] = 2'($urandom);
               rd[n] = 16'($urandom);
            end else if (act[n] && mb && gm == n &&
                         $urandom_range(0, 39) == 0) begin
               act[n] = 0;
               drp[n] = 1;
            end
         end
         m0_req = act[0]; m1_req = act[1];
         m0_adr = ra[0]; m1_adr = ra[1];
         m0_write = rw[0]; m1_write = rw[1];
         m0_sel = rs[0]; m1_sel = rs[1];
         m0_wdata = rd[0]; m1_wdata = rd[1];
         s_ack = ($urandom_range(0, 99) < pct);
         s_rdata = 16'($urandom);
         #1;
         tmo_e = mb && !s_ack && age == int'(TO);
         dn = mb && (s_ack || tmo_e);
         ea[0] = dn && gm == 0;
         ea[1] = dn && gm == 1;
         chk("r_sreq", s_req, mb);
         chk("r_busy", busy, mb);
         chk("r_m0_ack", m0_ack, ea[0]);
         chk("r_m1_ack", m1_ack, ea[1]);
         chk("r_m0_err", m0_err, tmo_e && gm == 0);
         chk("r_m1_err", m1_err, tmo_e && gm == 1);
         if (ea[0])
            chk("r_m0_rd", m0_rdata,
                tmo_e ? 16'h0 : s_rdata);
         if (ea[1])
            chk("r_m1_rd", m1_rdata,
                tmo_e ? 16'h0 : s_rdata);
         if (mb) begin
            chk("r_adr", s_adr, la);
            chk("r_we", s_write, lw);
            chk("r_sel", s_sel, ls);
            chk("r_wd", s_wdata, ld);
         end
         if (!mb) begin
            if (act[0] || act[1]) begin
               if (act[0] && act[1])
                  p = (last == 0) ? 1 : 0;
               else
                  p = act[0] ? 0 : 1;
               last = p; gm = p;
               mb = 1; age = 0;
               la = ra[p]; lw = rw[p];
               ls = rs[p]; ld = rd[p];
            end
         end else if (dn) begin
            mb = 0;
         end else begin
            age++;
         end
         for (int n = 0; n < 2; n++) begin
            if (ea[n]) begin
               act[n] = 0;
               drp[n] = 0;
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 8'd255, cycles a granted transaction waits for s_ack before it is aborted.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 m0_adr  input  18  fetch master word address.
REQ-005 m0_req, m0_write  input  1 each  fetch master request / write-enable.
REQ-006 m0_sel  input  2  fetch master byte lanes {UB,LB}.
REQ-007 m0_wdata  input  16  fetch master write data.
REQ-008 m0_ack, m0_err  output  1 each  fetch master completion pulse / timeout flag.
REQ-009 m0_rdata  output  16  fetch master read data.
REQ-010 m1_*  same set, widths and directions as m0_*; data master.
REQ-011 s_adr 18, s_req 1, s_write 1, s_sel 2, s_wdata 16  outputs  downstream port to the SRAM controller's a-port.
REQ-012 s_ack 1, s_rdata 16  inputs  downstream completion pulse / read data.
REQ-013 busy  output  1  high while a transaction is outstanding.

Function
REQ-014 States: IDLE, BUSY; a master's req, adr, write, sel and wdata shall be held stable until its ack.
REQ-015 In IDLE with exactly one mN_req high, the next edge shall grant N, register its adr/write/sel/wdata onto s_*, assert s_req and enter BUSY.
REQ-016 In IDLE with both requests high, the grant shall go to the master not granted last; the last-grant pointer resets to 1, so m0 wins the first tie.
REQ-017 In BUSY, s_req and the latched s_* fields shall remain constant until completion.
REQ-018 mN_ack shall equal s_ack AND (granted master == N) AND BUSY, combinationally; mN_rdata shall pass s_rdata through; the non-granted master sees ack=0.
REQ-019 On the edge where s_ack is sampled in BUSY: s_req deasserts, state returns to IDLE; one IDLE cycle with s_req low separates consecutive transactions.
REQ-020 Latency: req high in cycle 0 -> s_req high in cycle 1 -> mN_ack in the same cycle as s_ack.
REQ-021 A 8-bit wait counter shall clear on grant and increment each BUSY cycle without s_ack.
REQ-022 When the counter equals TIMEOUT with no s_ack: pulse the granted mN_ack and mN_err for one cycle, drive mN_rdata 16'h0000, drop s_req, return to IDLE.
REQ-023 s_ack arriving in IDLE shall be ignored.
REQ-024 s_ack in the same cycle as the timeout condition shall be treated as normal completion; err stays 0.
REQ-025 A master dropping req while BUSY shall not abort; the transaction completes and ack still pulses.
REQ-026 busy shall equal (state == BUSY).

Reset
REQ-027 Asserting rst shall immediately force: state IDLE, s_req 0, s_write 0, s_sel 0, s_adr 0, s_wdata 0, last-grant 1, counter 0.
REQ-028 During reset, m0_ack, m1_ack, m0_err, m1_err and busy shall be 0.
REQ-029 Reset mid-transaction shall abandon it without issuing an ack; a late s_ack after release shall be ignored.

Structure
REQ-030 Package mem_pkg shall hold ADR_W=18, DAT_W=16, SEL_W=2 and the state enum; shared with the SRAM controller and core.
REQ-031 One sub-module, arb_rr2, shall hold the two-way round-robin pick and the last-grant pointer.

Verification
REQ-032 m0 reads 18'h00010 with the slave acking in 3 cycles and rdata 16'hBEEF -> s_req rises one cycle after m0_req; m0_ack and m0_rdata=16'hBEEF arrive with s_ack; m1_ack stays 0.
REQ-033 Both masters request from reset -> m0 granted first, then m1 after one idle cycle, then m0 again while both are held.
REQ-034 m1 writes adr 18'h3FFFF, sel 2'b01, wdata 16'h00A5 -> s_* carry exactly these values and s_write=1 throughout BUSY.
REQ-035 The slave never acks -> after TIMEOUT cycles, m0_ack and m0_err pulse together for one cycle with rdata 0, and s_req falls.
REQ-036 rst is asserted in the second cycle of BUSY -> s_req is low asynchronously; after release an s_ack produces no mN_ack.
REQ-037 s_ack coincides with the TIMEOUT cycle -> ack=1, err=0.
